// File: rtl/regfile_scoreboard_if.sv
// Bus between decode/write-back control and the register file with its busy scoreboard.
// Issue and write are accepted unconditionally at every rising edge (no ready); the consumer stalls on BusyX.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   ReadRegA;
    logic [ADDR_W-1:0]   ReadRegB;
    logic [DATA_W-1:0]   ReadDataA;
    logic [DATA_W-1:0]   ReadDataB;
    logic                BusyA;
    logic                BusyB;
    logic [ADDR_W-1:0]   WriteReg;
    logic [DATA_W-1:0]   WriteData;
    logic                WE;
    logic [DATA_W/8-1:0] ByteEn;
    logic [ADDR_W-1:0]   IssueReg;
    logic                IssueValid;
    logic [ADDR_W:0]     PendingCount;

    modport master (
        output ReadRegA, ReadRegB, WriteReg, WriteData, WE, ByteEn, IssueReg, IssueValid,
        input  ReadDataA, ReadDataB, BusyA, BusyB, PendingCount
    );

    modport slave (
        input  ReadRegA, ReadRegB, WriteReg, WriteData, WE, ByteEn, IssueReg, IssueValid,
        output ReadDataA, ReadDataB, BusyA, BusyB, PendingCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with byte-enable writes, optional write-to-read forwarding,
// and a per-register busy scoreboard with an incrementally tracked pending count.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic CLK,
    input logic CLR,
    regfile_scoreboard_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;
    localparam bit HasBypass = (BYPASS != 0);
    localparam bit HasZero = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] CountOne = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W:0]   pendCnt;

    logic [DATA_W-1:0] merged;
    logic writeOk, issueOk, incCnt, decCnt;
    logic zeroA, zeroB, fwdA, fwdB;

    assign writeOk = rf.WE && !(HasZero && rf.WriteReg == '0);
    assign issueOk = rf.IssueValid && !(HasZero && rf.IssueReg == '0);

    // Same-register issue+retire leaves the bit set, so only a fresh set counts up
    // and a retire counts down only when no issue re-claims that register.
    assign incCnt = issueOk && !busy[rf.IssueReg];
    assign decCnt = rf.WE && busy[rf.WriteReg] && !(issueOk && rf.IssueReg == rf.WriteReg);

    always_comb begin
        merged = mem[rf.WriteReg];
        for (int i = 0; i < LANES; i++) begin
            if (rf.ByteEn[i]) merged[8*i +: 8] = rf.WriteData[8*i +: 8];
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else if (writeOk) begin
            mem[rf.WriteReg] <= merged;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            busy    <= '0;
            pendCnt <= '0;
        end else begin
            if (rf.WE)   busy[rf.WriteReg] <= 1'b0;
            if (issueOk) busy[rf.IssueReg] <= 1'b1;
            case ({incCnt, decCnt})
                2'b10:   pendCnt <= pendCnt + CountOne;
                2'b01:   pendCnt <= pendCnt - CountOne;
                default: pendCnt <= pendCnt;
            endcase
        end
    end

    assign zeroA = HasZero && rf.ReadRegA == '0;
    assign zeroB = HasZero && rf.ReadRegB == '0;
    assign fwdA  = HasBypass && writeOk && rf.WriteReg == rf.ReadRegA;
    assign fwdB  = HasBypass && writeOk && rf.WriteReg == rf.ReadRegB;

    always_comb begin
        rf.ReadDataA = mem[rf.ReadRegA];
        rf.BusyA     = busy[rf.ReadRegA];
        if (zeroA) begin
            rf.ReadDataA = '0;
            rf.BusyA     = 1'b0;
        end else if (fwdA) begin
            rf.ReadDataA = merged;
            rf.BusyA     = 1'b0;
        end
    end

    always_comb begin
        rf.ReadDataB = mem[rf.ReadRegB];
        rf.BusyB     = busy[rf.ReadRegB];
        if (zeroB) begin
            rf.ReadDataB = '0;
            rf.BusyB     = 1'b0;
        end else if (fwdB) begin
            rf.ReadDataB = merged;
            rf.BusyB     = 1'b0;
        end
    end

    assign rf.PendingCount = pendCnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a forwarding build and a non-forwarding build driven with identical stimulus.
module tb_regfile_scoreboard;
    logic CLK;
    logic CLR;

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;

    logic [31:0] exp_q[$];

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) rfA ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) rfB ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .CLK (CLK),
        .CLR (CLR),
        .rf  (rfA.slave)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_dutNoBypass (
        .CLK (CLK),
        .CLR (CLR),
        .rf  (rfB.slave)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // driver tasks
    task automatic setRead(input logic [4:0] a, input logic [4:0] b);
        rfA.ReadRegA = a; rfA.ReadRegB = b;
        rfB.ReadRegA = a; rfB.ReadRegB = b;
    endtask

    task automatic setWrite(input logic we, input logic [4:0] r, input logic [31:0] d, input logic [3:0] be);
        rfA.WE = we; rfA.WriteReg = r; rfA.WriteData = d; rfA.ByteEn = be;
        rfB.WE = we; rfB.WriteReg = r; rfB.WriteData = d; rfB.ByteEn = be;
    endtask

    task automatic setIssue(input logic v, input logic [4:0] r);
        rfA.IssueValid = v; rfA.IssueReg = r;
        rfB.IssueValid = v; rfB.IssueReg = r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic writeReg(input logic [4:0] r, input logic [31:0] d, input logic [3:0] be);
        setWrite(1'b1, r, d, be);
        tick();
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic issueReg(input logic [4:0] r);
        setIssue(1'b1, r);
        tick();
        setIssue(1'b0, 5'd0);
    endtask

    // scoreboard comparison
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        assert (obs === exp) begin
            passCnt++;
        end else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        CLR = 1'b0;
        setRead(5'd1, 5'd2);
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        setIssue(1'b0, 5'd0);
        repeat (3) tick();
        CLR = 1'b1;
        settle();
        check("rst_dataA", 64'(rfA.ReadDataA), 64'h0);
        check("rst_busyA", 64'(rfA.BusyA), 64'h0);
        check("rst_pendA", 64'(rfA.PendingCount), 64'h0);
        check("rst_pendB", 64'(rfB.PendingCount), 64'h0);

        // T1: load 1..31, read back through the expected queue, then reset mid-cycle
        for (int i = 1; i < 32; i++) begin
            logic [31:0] v;
            v = 32'(i) * 32'h1111_1111;
            writeReg(5'(i), v, 4'hF);
            exp_q.push_back(v);
        end
        for (int i = 1; i < 32; i++) begin
            logic [31:0] e;
            setRead(5'(i), 5'(i));
            settle();
            e = exp_q.pop_front();
            check($sformatf("load_r%0d", i), 64'(rfA.ReadDataA), 64'(e));
        end
        check("load_r31_nobyp", 64'(rfB.ReadDataB), 64'h1111_110F);
        issueReg(5'd1);
        issueReg(5'd2);
        issueReg(5'd3);
        setRead(5'd1, 5'd2);
        settle();
        check("t1_pend3", 64'(rfA.PendingCount), 64'd3);
        check("t1_busyA_pre", 64'(rfA.BusyA), 64'd1);
        #2;
        CLR = 1'b0;
        #1;
        check("t1_rst_dataA", 64'(rfA.ReadDataA), 64'h0);
        check("t1_rst_dataB", 64'(rfA.ReadDataB), 64'h0);
        check("t1_rst_busyA", 64'(rfA.BusyA), 64'h0);
        check("t1_rst_busyB", 64'(rfA.BusyB), 64'h0);
        check("t1_rst_pendA", 64'(rfA.PendingCount), 64'h0);
        check("t1_rst_pendB", 64'(rfB.PendingCount), 64'h0);
        setIssue(1'b1, 5'd5);
        setWrite(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF);
        setRead(5'd5, 5'd5);
        tick();
        settle();
        check("t1_hold_pend", 64'(rfA.PendingCount), 64'h0);
        check("t1_hold_data", 64'(rfB.ReadDataA), 64'h0);
        setIssue(1'b0, 5'd0);
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        tick();
        CLR = 1'b1;
        tick();

        // T2: byte-lane write and forwarding
        writeReg(5'd5, 32'hAABB_CCDD, 4'hF);
        setRead(5'd5, 5'd5);
        setWrite(1'b1, 5'd5, 32'h1122_3344, 4'b0101);
        settle();
        check("t2_bypass", 64'(rfA.ReadDataA), 64'hAA22_CC44);
        check("t2_nobyp_old", 64'(rfB.ReadDataA), 64'hAABB_CCDD);
        tick();
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        settle();
        check("t2_stored", 64'(rfA.ReadDataA), 64'hAA22_CC44);
        check("t2_stored_nobyp", 64'(rfB.ReadDataB), 64'hAA22_CC44);

        // T3: register 0 is immune
        setRead(5'd0, 5'd0);
        setWrite(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
        setIssue(1'b1, 5'd0);
        settle();
        check("t3_data_same", 64'(rfA.ReadDataA), 64'h0);
        check("t3_busy_same", 64'(rfA.BusyA), 64'h0);
        tick();
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        setIssue(1'b0, 5'd0);
        settle();
        check("t3_data_after", 64'(rfB.ReadDataA), 64'h0);
        check("t3_pend", 64'(rfA.PendingCount), 64'h0);

        // T4: issue then retire
        issueReg(5'd7);
        setRead(5'd7, 5'd7);
        settle();
        check("t4_busy", 64'(rfA.BusyA), 64'd1);
        check("t4_pend1", 64'(rfA.PendingCount), 64'd1);
        setWrite(1'b1, 5'd7, 32'h0000_1234, 4'hF);
        settle();
        check("t4_busy_fwd", 64'(rfA.BusyA), 64'd0);
        check("t4_data_fwd", 64'(rfA.ReadDataA), 64'h1234);
        check("t4_busy_nobyp", 64'(rfB.BusyA), 64'd1);
        check("t4_pend_still1", 64'(rfA.PendingCount), 64'd1);
        tick();
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        settle();
        check("t4_pend0", 64'(rfA.PendingCount), 64'd0);
        check("t4_busy_after", 64'(rfB.BusyA), 64'd0);
        check("t4_data_after", 64'(rfB.ReadDataA), 64'h1234);

        // T5: collisions, write to idle register, all-zero ByteEn retire
        issueReg(5'd9);
        setIssue(1'b1, 5'd9);
        setWrite(1'b1, 5'd9, 32'h99, 4'hF);
        tick();
        setIssue(1'b0, 5'd0);
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        setRead(5'd9, 5'd10);
        settle();
        check("t5_same_busy", 64'(rfA.BusyA), 64'd1);
        check("t5_same_pend", 64'(rfA.PendingCount), 64'd1);
        setIssue(1'b1, 5'd10);
        setWrite(1'b1, 5'd9, 32'hAA, 4'hF);
        tick();
        setIssue(1'b0, 5'd0);
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        settle();
        check("t5_diff_pend", 64'(rfA.PendingCount), 64'd1);
        check("t5_r9_free", 64'(rfA.BusyA), 64'd0);
        check("t5_r10_busy", 64'(rfA.BusyB), 64'd1);
        check("t5_r9_data", 64'(rfB.ReadDataA), 64'hAA);
        writeReg(5'd11, 32'h55, 4'hF);
        settle();
        check("t5_idle_write", 64'(rfA.PendingCount), 64'd1);
        writeReg(5'd10, 32'hFFFF_FFFF, 4'h0);
        settle();
        check("t5_be0_pend", 64'(rfA.PendingCount), 64'd0);
        check("t5_be0_busy", 64'(rfA.BusyB), 64'd0);
        check("t5_be0_data", 64'(rfA.ReadDataB), 64'h0);

        // T6: non-forwarding latency and full scoreboard
        writeReg(5'd4, 32'h4444_4444, 4'hF);
        setRead(5'd4, 5'd4);
        setWrite(1'b1, 5'd4, 32'hDEAD_BEEF, 4'hF);
        settle();
        check("t6_nobyp_old", 64'(rfB.ReadDataA), 64'h4444_4444);
        check("t6_byp_new", 64'(rfA.ReadDataA), 64'hDEAD_BEEF);
        tick();
        setWrite(1'b0, 5'd0, 32'd0, 4'd0);
        settle();
        check("t6_nobyp_new", 64'(rfB.ReadDataA), 64'hDEAD_BEEF);
        for (int i = 0; i < 32; i++) issueReg(5'(i));
        settle();
        check("t6_pend31", 64'(rfA.PendingCount), 64'd31);
        check("t6_pend31_nobyp", 64'(rfB.PendingCount), 64'd31);
        issueReg(5'd5);
        settle();
        check("t6_waw", 64'(rfA.PendingCount), 64'd31);
        setRead(5'd31, 5'd0);
        settle();
        check("t6_busy31", 64'(rfB.BusyA), 64'd1);
        check("t6_busy0", 64'(rfB.BusyB), 64'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
